// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants, keypad key codes and decoder state types
package calc_pkg;

  localparam logic [1:0] SUMA  = 2'd1;
  localparam logic [1:0] RESTA = 2'd2;
  localparam logic [1:0] MULT  = 2'd3;

  // Key code is {row, col}; row 0 / col 0 is the top-left key.
  localparam logic [3:0] K_1    = 4'd0;
  localparam logic [3:0] K_2    = 4'd1;
  localparam logic [3:0] K_3    = 4'd2;
  localparam logic [3:0] K_A    = 4'd3;
  localparam logic [3:0] K_4    = 4'd4;
  localparam logic [3:0] K_5    = 4'd5;
  localparam logic [3:0] K_6    = 4'd6;
  localparam logic [3:0] K_B    = 4'd7;
  localparam logic [3:0] K_7    = 4'd8;
  localparam logic [3:0] K_8    = 4'd9;
  localparam logic [3:0] K_9    = 4'd10;
  localparam logic [3:0] K_C    = 4'd11;
  localparam logic [3:0] K_AST  = 4'd12;
  localparam logic [3:0] K_0    = 4'd13;
  localparam logic [3:0] K_HASH = 4'd14;
  localparam logic [3:0] K_D    = 4'd15;

  typedef enum logic [2:0] {
    BARRIDO,
    REBOTE_P,
    EMITIR,
    ESPERA_SOLTAR,
    REBOTE_S
  } teclado_estado_t;

  typedef enum logic [2:0] {
    ACC_NINGUNA,
    ACC_DIGITO,
    ACC_OPERANDO,
    ACC_IGUAL,
    ACC_BORRAR
  } accion_t;

  typedef struct packed {
    accion_t    accion;
    logic [3:0] valor;
  } tecla_dec_t;

endpackage

// File: rtl/teclado_decoder_if.sv
// rtl/teclado_decoder_if.sv - command pulses from the keypad decoder to the calculator FSM
interface teclado_decoder_if;
  logic       digito_en;
  logic [3:0] digito;
  logic       operando_en;
  logic [1:0] que_operacion;
  logic       igual_en;
  logic       borrar_en;

  modport master (
    output digito_en, digito, operando_en, que_operacion, igual_en, borrar_en
  );

  modport slave (
    input digito_en, digito, operando_en, que_operacion, igual_en, borrar_en
  );
endinterface

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchroniser, resets to all ones (idle pulled-up lines)
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/teclado_decoder.sv
// rtl/teclado_decoder.sv - 4x4 keypad scanner/debouncer producing one command pulse per press
module teclado_decoder
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         filas,
  output logic [3:0]         columnas,
  teclado_decoder_if.master  cmd
);

  localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  function automatic logic [1:0] fila_baja(input logic [3:0] f);
    if (!f[0])      return 2'd0;
    else if (!f[1]) return 2'd1;
    else if (!f[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic tecla_dec_t decodifica(input logic [3:0] codigo);
    tecla_dec_t d;
    d.accion = ACC_DIGITO;
    d.valor  = 4'd0;
    case (codigo)
      K_1:     d.valor = 4'd1;
      K_2:     d.valor = 4'd2;
      K_3:     d.valor = 4'd3;
      K_4:     d.valor = 4'd4;
      K_5:     d.valor = 4'd5;
      K_6:     d.valor = 4'd6;
      K_7:     d.valor = 4'd7;
      K_8:     d.valor = 4'd8;
      K_9:     d.valor = 4'd9;
      K_0:     d.valor = 4'd0;
      K_A:     begin d.accion = ACC_OPERANDO; d.valor = {2'b00, SUMA};  end
      K_B:     begin d.accion = ACC_OPERANDO; d.valor = {2'b00, RESTA}; end
      K_C:     begin d.accion = ACC_OPERANDO; d.valor = {2'b00, MULT};  end
      K_HASH:  d.accion = ACC_IGUAL;
      K_AST:   d.accion = ACC_BORRAR;
      default: d.accion = ACC_NINGUNA;
    endcase
    return d;
  endfunction

  logic [3:0]        filas_s;
  teclado_estado_t   estado, estado_n;
  logic [1:0]        idx, idx_n;
  logic [SCAN_W-1:0] scan_cnt, scan_n;
  logic [DEB_W-1:0]  deb_cnt, deb_n;
  logic [3:0]        patron, patron_n;
  logic [3:0]        codigo, codigo_n;
  tecla_dec_t        dec;
  logic              emitir;

  sincronizador_2ff #(.WIDTH(4)) u_sinc (
    .clk   (clk),
    .reset (reset),
    .d     (filas),
    .q     (filas_s)
  );

  assign columnas = ~(4'b0001 << idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= BARRIDO;
      idx      <= 2'd0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      patron   <= 4'hF;
      codigo   <= 4'd0;
    end else begin
      estado   <= estado_n;
      idx      <= idx_n;
      scan_cnt <= scan_n;
      deb_cnt  <= deb_n;
      patron   <= patron_n;
      codigo   <= codigo_n;
    end
  end

  always_comb begin
    estado_n = estado;
    idx_n    = idx;
    scan_n   = scan_cnt;
    deb_n    = deb_cnt;
    patron_n = patron;
    codigo_n = codigo;
    case (estado)
      BARRIDO: begin
        if (filas_s != 4'hF) begin
          patron_n = filas_s;
          deb_n    = '0;
          estado_n = REBOTE_P;
        end else if (scan_cnt >= SCAN_LAST) begin
          scan_n = '0;
          idx_n  = idx + 2'd1;
        end else begin
          scan_n = scan_cnt + SCAN_W'(1);
        end
      end
      REBOTE_P: begin
        if (filas_s != patron) begin
          scan_n   = '0;
          estado_n = BARRIDO;
        end else if (deb_cnt >= DEB_LAST) begin
          codigo_n = {fila_baja(patron), idx};
          estado_n = EMITIR;
        end else begin
          deb_n = deb_cnt + DEB_W'(1);
        end
      end
      EMITIR: estado_n = ESPERA_SOLTAR;
      ESPERA_SOLTAR: begin
        if (filas_s == 4'hF) begin
          deb_n    = '0;
          estado_n = REBOTE_S;
        end
      end
      REBOTE_S: begin
        if (filas_s != 4'hF) begin
          estado_n = ESPERA_SOLTAR;
        end else if (deb_cnt >= DEB_LAST) begin
          // Preloading the timer makes the first scanning cycle step to the next column.
          scan_n   = SCAN_LAST;
          estado_n = BARRIDO;
        end else begin
          deb_n = deb_cnt + DEB_W'(1);
        end
      end
      default: estado_n = BARRIDO;
    endcase
  end

  assign emitir = (estado_n == EMITIR);
  assign dec    = decodifica(codigo_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd.digito_en     <= 1'b0;
      cmd.operando_en   <= 1'b0;
      cmd.igual_en      <= 1'b0;
      cmd.borrar_en     <= 1'b0;
      cmd.digito        <= 4'd0;
      cmd.que_operacion <= 2'd0;
    end else begin
      cmd.digito_en   <= emitir && (dec.accion == ACC_DIGITO);
      cmd.operando_en <= emitir && (dec.accion == ACC_OPERANDO);
      cmd.igual_en    <= emitir && (dec.accion == ACC_IGUAL);
      cmd.borrar_en   <= emitir && (dec.accion == ACC_BORRAR);
      if (emitir && (dec.accion == ACC_DIGITO))   cmd.digito        <= dec.valor;
      if (emitir && (dec.accion == ACC_OPERANDO)) cmd.que_operacion <= dec.valor[1:0];
    end
  end

endmodule

// File: tb/tb_teclado_decoder.sv
// tb/tb_teclado_decoder.sv - directed self-checking bench for teclado_decoder
module tb_teclado_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [15:0] pulsada = 16'h0000;

  int checks = 0;
  int errors = 0;
  int ciclo = 0;
  int cnt_dig = 0, cnt_op = 0, cnt_ig = 0, cnt_bo = 0, cnt_multi = 0;

  teclado_decoder_if cmd_if ();

  teclado_decoder #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .filas    (filas),
    .columnas (columnas),
    .cmd      (cmd_if)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) filas[r] = ~|(pulsada[r*4 +: 4] & ~columnas);
  end

  always @(negedge clk) begin
    ciclo = ciclo + 1;
    if (cmd_if.digito_en)   cnt_dig = cnt_dig + 1;
    if (cmd_if.operando_en) cnt_op  = cnt_op + 1;
    if (cmd_if.igual_en)    cnt_ig  = cnt_ig + 1;
    if (cmd_if.borrar_en)   cnt_bo  = cnt_bo + 1;
    if ((32'(cmd_if.digito_en) + 32'(cmd_if.operando_en) + 32'(cmd_if.igual_en) + 32'(cmd_if.borrar_en)) > 1)
      cnt_multi = cnt_multi + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  function automatic int total_pulsos();
    return cnt_dig + cnt_op + cnt_ig + cnt_bo;
  endfunction

  task automatic esperar_pulso(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cmd_if.digito_en || cmd_if.operando_en || cmd_if.igual_en || cmd_if.borrar_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic esperar_columna(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (columnas == c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pulsada = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (columnas !== 4'b1110) begin errors++; $display("FAIL reset_columnas got %b expected 1110", columnas); end
    checks++;
    if (cmd_if.digito !== 4'd0 || cmd_if.que_operacion !== 2'd0) begin
      errors++; $display("FAIL reset_datos got digito=%0d que=%0d expected 0 0", cmd_if.digito, cmd_if.que_operacion);
    end
    checks++;
    if ({cmd_if.digito_en, cmd_if.operando_en, cmd_if.igual_en, cmd_if.borrar_en} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulsos got %b expected 0000",
                         {cmd_if.digito_en, cmd_if.operando_en, cmd_if.igual_en, cmd_if.borrar_en});
    end
  endtask

  task automatic test_idle();
    int base;
    logic [3:0] esperado;
    int err_col;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = total_pulsos();
    err_col = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      esperado = ~(4'b0001 << ((n / 4) % 4));
      checks++;
      if (columnas !== esperado) begin
        errors++;
        if (err_col < 4) $display("FAIL idle_columnas cycle %0d got %b expected %b", n, columnas, esperado);
        err_col++;
      end
    end
    checks++;
    if (total_pulsos() != base) begin errors++; $display("FAIL idle_pulsos got %0d expected 0", total_pulsos() - base); end
  endtask

  task automatic test_tecla5();
    int base;
    bit ok1, ok2;
    esperar_columna(4'b1110, ok1);
    esperar_columna(4'b1101, ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL k5_scan_timeout got no column 1 expected 1101"); end
    base = cnt_dig;
    pulsada[5] = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (cmd_if.digito_en !== 1'b0) begin errors++; $display("FAIL k5_early got %b expected 0", cmd_if.digito_en); end
    @(negedge clk);
    checks++;
    if (cmd_if.digito_en !== 1'b1) begin errors++; $display("FAIL k5_latency got %b expected 1", cmd_if.digito_en); end
    checks++;
    if (cmd_if.digito !== 4'd5) begin errors++; $display("FAIL k5_digito got %0d expected 5", cmd_if.digito); end
    repeat (29) @(negedge clk);
    checks++;
    if (columnas !== 4'b1101) begin errors++; $display("FAIL k5_frozen got %b expected 1101", columnas); end
    checks++;
    if (cnt_dig - base != 1) begin errors++; $display("FAIL k5_held_count got %0d expected 1", cnt_dig - base); end
    pulsada[5] = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (cnt_dig - base != 1) begin errors++; $display("FAIL k5_release_count got %0d expected 1", cnt_dig - base); end
  endtask

  task automatic test_rebote_b();
    int base_op, base_tot;
    bit ok;
    base_op = cnt_op;
    base_tot = total_pulsos();
    for (int i = 0; i < 20; i++) begin
      pulsada[7] = ((i / 3) % 2) == 0;
      @(negedge clk);
    end
    pulsada[7] = 1'b1;
    esperar_pulso(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b_timeout got no pulse expected operando_en"); end
    checks++;
    if (cmd_if.operando_en !== 1'b1 || cmd_if.que_operacion !== 2'd2) begin
      errors++; $display("FAIL b_operacion got en=%b que=%0d expected en=1 que=2", cmd_if.operando_en, cmd_if.que_operacion);
    end
    repeat (20) @(negedge clk);
    pulsada[7] = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (cnt_op - base_op != 1 || total_pulsos() - base_tot != 1) begin
      errors++; $display("FAIL b_count got op=%0d total=%0d expected 1 1", cnt_op - base_op, total_pulsos() - base_tot);
    end
  endtask

  task automatic test_igual_c();
    int t1, t2;
    bit ok;
    pulsada[14] = 1'b1;
    esperar_pulso(100, ok);
    t1 = ciclo;
    checks++;
    if (!ok || cmd_if.igual_en !== 1'b1) begin errors++; $display("FAIL hash_igual got %b expected 1", cmd_if.igual_en); end
    repeat (5) @(negedge clk);
    pulsada[14] = 1'b0;
    repeat (25) @(negedge clk);
    pulsada[11] = 1'b1;
    esperar_pulso(100, ok);
    t2 = ciclo;
    checks++;
    if (!ok || cmd_if.operando_en !== 1'b1 || cmd_if.que_operacion !== 2'd3) begin
      errors++; $display("FAIL c_operacion got en=%b que=%0d expected en=1 que=3", cmd_if.operando_en, cmd_if.que_operacion);
    end
    checks++;
    if (t2 - t1 < 19) begin errors++; $display("FAIL pulse_spacing got %0d expected >=19", t2 - t1); end
    repeat (5) @(negedge clk);
    pulsada[11] = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_simultaneas();
    int base;
    bit ok;
    base = total_pulsos();
    pulsada[0] = 1'b1;
    pulsada[8] = 1'b1;
    esperar_pulso(100, ok);
    checks++;
    if (!ok || cmd_if.digito_en !== 1'b1 || cmd_if.digito !== 4'd1) begin
      errors++; $display("FAIL multi_row got en=%b digito=%0d expected en=1 digito=1", cmd_if.digito_en, cmd_if.digito);
    end
    repeat (5) @(negedge clk);
    pulsada[0] = 1'b0;
    pulsada[8] = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (total_pulsos() - base != 1) begin errors++; $display("FAIL multi_row_count got %0d expected 1", total_pulsos() - base); end
    pulsada[15] = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (total_pulsos() - base != 1) begin errors++; $display("FAIL key_d_pulse got %0d expected 1", total_pulsos() - base); end
    checks++;
    if (columnas !== 4'b0111) begin errors++; $display("FAIL key_d_frozen got %b expected 0111", columnas); end
    pulsada[15] = 1'b0;
    repeat (25) @(negedge clk);
    pulsada[12] = 1'b1;
    esperar_pulso(100, ok);
    checks++;
    if (!ok || cmd_if.borrar_en !== 1'b1) begin errors++; $display("FAIL ast_borrar got %b expected 1", cmd_if.borrar_en); end
    repeat (5) @(negedge clk);
    pulsada[12] = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_reset_rebote();
    int base;
    bit ok1, ok2;
    esperar_columna(4'b1101, ok1);
    esperar_columna(4'b1011, ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL k9_scan_timeout got no column 2 expected 1011"); end
    base = total_pulsos();
    pulsada[10] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    pulsada[10] = 1'b0;
    @(negedge clk);
    checks++;
    if (columnas !== 4'b1110 || cmd_if.digito !== 4'd0) begin
      errors++; $display("FAIL k9_reset got columnas=%b digito=%0d expected 1110 0", columnas, cmd_if.digito);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (total_pulsos() != base) begin errors++; $display("FAIL k9_pulse got %0d expected 0", total_pulsos() - base); end
  endtask

  task automatic test_exclusivos();
    checks++;
    if (cnt_multi != 0) begin errors++; $display("FAIL pulse_overlap got %0d expected 0", cnt_multi); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_tecla5();
    test_rebote_b();
    test_igual_c();
    test_simultaneas();
    test_reset_rebote();
    test_exclusivos();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
